// File: rtl/associative_memory_chunked.sv
// associative_memory_chunked
//   Stores up to NUM_CLASSES prototype hypervectors, each with a valid bit.
//   A query is classified by minimum Hamming distance. The distance is
//   accumulated word-serially, CHUNK_WIDTH bits per cycle. The block also
//   reports the runner-up distance and a no-match flag.
//
// Ports
//   Clk_CI / Reset_RI          clock, synchronous active-high reset
//   ValidIn_SI / ReadyOut_SO   input handshake
//   ModeIn_SI                  00 predict, 01 train, 10 clear-all, 11 dropped
//   LabelIn_DI                 slot written by train
//   HypervectorIn_DI           query (predict) or prototype (train)
//   ValidOut_SO / ReadyIn_SI   result handshake
//   LabelOut_DO                winning class
//   DistanceOut_DO             winning Hamming distance
//   SecondDistanceOut_DO       runner-up Hamming distance
//   NoMatch_SO                 no class was valid when the predict ran
//
// State | meaning
//   IDLE    | ready for a transaction; train and clear complete here
//   COMPUTE | one chunk per cycle for every class, then one wrap-up cycle
//   OUTPUT  | result held until the downstream accepts it
module associative_memory_chunked #(
  parameter int HV_DIMENSION   = 2000,
  parameter int CHUNK_WIDTH    = 100,
  parameter int NUM_CLASSES    = 5,
  parameter int LABEL_WIDTH    = 3,
  parameter int DISTANCE_WIDTH = 11,
  parameter int MODE_WIDTH     = 2
) (
  input  logic                      Clk_CI,
  input  logic                      Reset_RI,
  input  logic                      ValidIn_SI,
  output logic                      ReadyOut_SO,
  input  logic [MODE_WIDTH-1:0]     ModeIn_SI,
  input  logic [LABEL_WIDTH-1:0]    LabelIn_DI,
  input  logic [0:HV_DIMENSION-1]   HypervectorIn_DI,
  output logic                      ValidOut_SO,
  input  logic                      ReadyIn_SI,
  output logic [LABEL_WIDTH-1:0]    LabelOut_DO,
  output logic [DISTANCE_WIDTH-1:0] DistanceOut_DO,
  output logic [DISTANCE_WIDTH-1:0] SecondDistanceOut_DO,
  output logic                      NoMatch_SO
);

  localparam int NUM_CHUNKS  = HV_DIMENSION / CHUNK_WIDTH;
  localparam int CHUNK_IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int CLASS_IDX_W = $clog2(NUM_CLASSES + 1);

  localparam logic [CHUNK_IDX_W-1:0] LAST_CHUNK = CHUNK_IDX_W'(NUM_CHUNKS - 1);
  // class_idx reaching NUM_CLASSES marks the wrap-up cycle that loads the
  // result registers; it makes the latency chunks*classes + 1.
  localparam logic [CLASS_IDX_W-1:0] CLASS_DONE = CLASS_IDX_W'(NUM_CLASSES);

  localparam logic [MODE_WIDTH-1:0] MODE_PREDICT = MODE_WIDTH'(0);
  localparam logic [MODE_WIDTH-1:0] MODE_TRAIN   = MODE_WIDTH'(1);
  localparam logic [MODE_WIDTH-1:0] MODE_CLEAR   = MODE_WIDTH'(2);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_OUTPUT  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [0:HV_DIMENSION-1]   proto_mem [NUM_CLASSES];
  logic [NUM_CLASSES-1:0]    class_valid;
  logic [0:HV_DIMENSION-1]   query;
  logic [CLASS_IDX_W-1:0]    class_idx;
  logic [CLASS_IDX_W-1:0]    class_sel;
  logic [CHUNK_IDX_W-1:0]    chunk_idx;
  logic [DISTANCE_WIDTH-1:0] acc;
  logic [DISTANCE_WIDTH-1:0] best;
  logic [DISTANCE_WIDTH-1:0] second;
  logic [LABEL_WIDTH-1:0]    best_label;
  logic                      found;

  logic [CHUNK_WIDTH-1:0]    chunk_diff;
  logic [DISTANCE_WIDTH-1:0] chunk_count;
  logic [DISTANCE_WIDTH-1:0] dist_sum;
  logic                      accept;
  logic                      label_in_range;

  assign accept         = ValidIn_SI & ReadyOut_SO;
  assign label_in_range = int'(LabelIn_DI) < NUM_CLASSES;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next  = state;
    ReadyOut_SO = 1'b0;
    ValidOut_SO = 1'b0;
    case (state)
      ST_IDLE: begin
        ReadyOut_SO = ~Reset_RI;
        if (ValidIn_SI && !Reset_RI && ModeIn_SI == MODE_PREDICT)
          state_next = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        if (class_idx == CLASS_DONE) state_next = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        ValidOut_SO = 1'b1;
        if (ReadyIn_SI) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------ chunk popcount
  // class_sel keeps the prototype read in range during the wrap-up cycle.
  assign class_sel  = (class_idx == CLASS_DONE) ? '0 : class_idx;
  assign chunk_diff = query[int'(chunk_idx) * CHUNK_WIDTH +: CHUNK_WIDTH]
                    ^ proto_mem[class_sel][int'(chunk_idx) * CHUNK_WIDTH +: CHUNK_WIDTH];

  always_comb begin
    chunk_count = '0;
    for (int i = 0; i < CHUNK_WIDTH; i++)
      chunk_count = chunk_count + DISTANCE_WIDTH'(chunk_diff[i]);
  end

  assign dist_sum = acc + chunk_count;

  // ------------------------------------------------------ prototype store
  // Contents are don't-care after reset; only the valid bits are cleared.
  always_ff @(posedge Clk_CI) begin
    if (accept && ModeIn_SI == MODE_TRAIN && label_in_range)
      proto_mem[LabelIn_DI] <= HypervectorIn_DI;
  end

  // ------------------------------------------------------------ datapath
  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      class_valid          <= '0;
      query                <= '0;
      class_idx            <= '0;
      chunk_idx            <= '0;
      acc                  <= '0;
      best                 <= '1;
      second               <= '1;
      best_label           <= '0;
      found                <= 1'b0;
      LabelOut_DO          <= '0;
      DistanceOut_DO       <= '0;
      SecondDistanceOut_DO <= '0;
      NoMatch_SO           <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (ModeIn_SI)
              MODE_TRAIN: begin
                if (label_in_range) class_valid[LabelIn_DI] <= 1'b1;
              end
              MODE_CLEAR: class_valid <= '0;
              MODE_PREDICT: begin
                query      <= HypervectorIn_DI;
                class_idx  <= '0;
                chunk_idx  <= '0;
                acc        <= '0;
                best       <= '1;
                second     <= '1;
                best_label <= '0;
                found      <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        ST_COMPUTE: begin
          if (class_idx != CLASS_DONE) begin
            if (chunk_idx == LAST_CHUNK) begin
              // Strict compares: the lower label keeps a tie, and the
              // equal distance drops into second place.
              if (class_valid[class_sel] && dist_sum < best) begin
                second     <= best;
                best       <= dist_sum;
                best_label <= LABEL_WIDTH'(class_idx);
                found      <= 1'b1;
              end else if (class_valid[class_sel] && dist_sum < second) begin
                second <= dist_sum;
              end
              acc       <= '0;
              chunk_idx <= '0;
              class_idx <= class_idx + 1'b1;
            end else begin
              acc       <= dist_sum;
              chunk_idx <= chunk_idx + 1'b1;
            end
          end else begin
            LabelOut_DO          <= best_label;
            DistanceOut_DO       <= best;
            SecondDistanceOut_DO <= second;
            NoMatch_SO           <= ~found;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_associative_memory_chunked.sv
module tb_associative_memory_chunked;

  localparam int HV  = 2000;
  localparam int NC  = 5;
  localparam int LW  = 3;
  localparam int DW  = 11;
  localparam int MW  = 2;
  localparam int SENT = 2047;
  localparam int LATENCY = 101;

  typedef logic [0:HV-1] hv_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          valid_in = 1'b0;
  logic          ready_out;
  logic [MW-1:0] mode_in = '0;
  logic [LW-1:0] label_in = '0;
  hv_t           hv_in = '0;
  logic          valid_out;
  logic          ready_in = 1'b0;
  logic [LW-1:0] label_out;
  logic [DW-1:0] dist_out;
  logic [DW-1:0] second_out;
  logic          nomatch;

  associative_memory_chunked dut (
    .Clk_CI(clk), .Reset_RI(rst),
    .ValidIn_SI(valid_in), .ReadyOut_SO(ready_out),
    .ModeIn_SI(mode_in), .LabelIn_DI(label_in), .HypervectorIn_DI(hv_in),
    .ValidOut_SO(valid_out), .ReadyIn_SI(ready_in),
    .LabelOut_DO(label_out), .DistanceOut_DO(dist_out),
    .SecondDistanceOut_DO(second_out), .NoMatch_SO(nomatch)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model
  bit  m_valid [NC];
  hv_t m_proto [NC];
  int  exp_label, exp_dist, exp_second, exp_nomatch;
  bit  exp_armed = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic hv_t first_n(input int n);
    hv_t v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic hv_t rand_hv();
    hv_t v;
    for (int i = 0; i < HV; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // Distances of all valid classes, sorted; best is the smallest, the
  // runner-up is the next entry of the sorted list (equal values included).
  task automatic model_predict(input hv_t q, output int lbl, output int d,
                               output int sec, output int nm);
    int ds[$];
    int sorted[$];
    ds = {};
    for (int c = 0; c < NC; c++)
      if (m_valid[c]) ds.push_back($countones(q ^ m_proto[c]));
    if (ds.size() == 0) begin
      lbl = 0; d = SENT; sec = SENT; nm = 1;
    end else begin
      sorted = ds;
      sorted.sort();
      d   = sorted[0];
      sec = (sorted.size() > 1) ? sorted[1] : SENT;
      nm  = 0;
      lbl = 0;
      for (int c = NC - 1; c >= 0; c--)
        if (m_valid[c] && $countones(q ^ m_proto[c]) == d) lbl = c;
    end
  endtask

  // compare process: every cycle the result is valid
  always @(negedge clk) begin
    if (!rst && valid_out) begin
      if (!exp_armed) check("unexpected_valid_out", 1, 0);
      else begin
        check("label_out", int'(label_out), exp_label);
        check("dist_out", int'(dist_out), exp_dist);
        check("second_out", int'(second_out), exp_second);
        check("nomatch", int'(nomatch), exp_nomatch);
        check("ready_out_in_output", int'(ready_out), 0);
      end
    end
  end

  task automatic send(input logic [MW-1:0] m, input int lbl, input hv_t v);
    @(negedge clk);
    mode_in  = m;
    label_in = LW'(lbl);
    hv_in    = v;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic train(input int lbl, input hv_t v);
    send(2'b01, lbl, v);
    if (lbl < NC) begin
      m_valid[lbl] = 1'b1;
      m_proto[lbl] = v;
    end
  endtask

  task automatic clear_all();
    send(2'b10, 0, '0);
    for (int c = 0; c < NC; c++) m_valid[c] = 1'b0;
  endtask

  // lit_* < 0 means no hand-computed literal for that field
  task automatic predict(input string tag, input hv_t q, input int hold,
                         input int lit_label, input int lit_dist,
                         input int lit_second, input int lit_nm);
    int n;
    bit seen;
    model_predict(q, exp_label, exp_dist, exp_second, exp_nomatch);
    exp_armed = 1'b1;
    if (lit_label  >= 0) check({tag, "_model_label"}, exp_label, lit_label);
    if (lit_dist   >= 0) check({tag, "_model_dist"}, exp_dist, lit_dist);
    if (lit_second >= 0) check({tag, "_model_second"}, exp_second, lit_second);
    if (lit_nm     >= 0) check({tag, "_model_nomatch"}, exp_nomatch, lit_nm);
    send(2'b00, 0, q);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 300) begin
      @(posedge clk);
      #1;
      n++;
      if (valid_out) seen = 1'b1;
    end
    check({tag, "_latency"}, n, LATENCY);
    if (seen) begin
      if (lit_label  >= 0) check({tag, "_label_lit"}, int'(label_out), lit_label);
      if (lit_dist   >= 0) check({tag, "_dist_lit"}, int'(dist_out), lit_dist);
      if (lit_second >= 0) check({tag, "_second_lit"}, int'(second_out), lit_second);
      if (lit_nm     >= 0) check({tag, "_nomatch_lit"}, int'(nomatch), lit_nm);
      repeat (hold) @(negedge clk);
      check({tag, "_valid_held"}, int'(valid_out), 1);
      @(negedge clk);
      ready_in = 1'b1;
      @(posedge clk);
      #1;
      ready_in = 1'b0;
      check({tag, "_valid_dropped"}, int'(valid_out), 0);
      check({tag, "_ready_back"}, int'(ready_out), 1);
      check({tag, "_label_retained"}, int'(label_out), exp_label);
      check({tag, "_dist_retained"}, int'(dist_out), exp_dist);
    end
    exp_armed = 1'b0;
  endtask

  hv_t v_pat;
  hv_t v_rand;

  initial begin
    for (int c = 0; c < NC; c++) begin
      m_valid[c] = 1'b0;
      m_proto[c] = '0;
    end
    for (int i = 0; i < HV; i++) v_pat[i] = (i % 3 == 0);

    // reset values
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready_out", int'(ready_out), 0);
    check("rst_valid_out", int'(valid_out), 0);
    check("rst_label_out", int'(label_out), 0);
    check("rst_dist_out", int'(dist_out), 0);
    check("rst_second_out", int'(second_out), 0);
    check("rst_nomatch", int'(nomatch), 0);
    rst = 1'b0;
    #1;
    check("idle_ready_out", int'(ready_out), 1);

    predict("empty", '0, 0, 0, SENT, SENT, 1);

    train(0, '0);
    train(2, first_n(300));
    predict("basic", first_n(100), 0, 0, 100, 200, 0);

    train(1, v_pat);
    train(3, v_pat);
    predict("tie", v_pat, 20, 1, 0, 0, 0);

    // out-of-range train must not touch slots 0-4
    train(6, ~hv_t'('0));
    predict("oor", '0, 0, 0, 0, 300, 0);

    // reserved mode is accepted and dropped
    send(2'b11, 0, ~hv_t'('0));
    check("reserved_ready", int'(ready_out), 1);
    check("reserved_no_valid", int'(valid_out), 0);

    train(4, first_n(50));
    clear_all();
    predict("cleared", first_n(10), 0, 0, SENT, SENT, 1);

    train(4, first_n(100));
    predict("single", '0, 3, 4, 100, SENT, 0);

    clear_all();
    train(0, ~hv_t'('0));
    train(1, ~hv_t'('0));
    predict("maxdist", '0, 0, 0, HV, HV, 0);

    // reset in the middle of a computation
    train(2, '0);
    send(2'b00, 0, '0);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_valid_out", int'(valid_out), 0);
    check("midrst_ready_in_rst", int'(ready_out), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < NC; c++) m_valid[c] = 1'b0;
    #1;
    check("midrst_ready_after", int'(ready_out), 1);
    repeat (3) @(negedge clk);
    check("midrst_no_valid", int'(valid_out), 0);
    predict("after_rst", '0, 0, 0, SENT, SENT, 1);

    // random prototypes and queries checked against the model only
    for (int c = 0; c < NC; c++) train(c, rand_hv());
    for (int k = 0; k < 3; k++) begin
      v_rand = rand_hv();
      predict("rand", v_rand, k, -1, -1, -1, 0);
    end
    v_rand = m_proto[3];
    predict("rand_exact", v_rand, 0, 3, 0, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d, expected 0", 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/associative_memory_chunked.md
Name: associative_memory_chunked

Overview:
Parametrised successor to the current associative memory. Stores up to NUM_CLASSES prototype hypervectors with per-class valid bits and classifies a query by minimum Hamming distance. Distance is computed word-serially, CHUNK_WIDTH bits per cycle, trading latency for area. Also reports the runner-up distance (confidence margin) and a no-match flag. Sits between the encoder/spatial-temporal stage and the result sink, on the same valid/ready handshake.

Parameters:
HV_DIMENSION, 2000, hypervector length in bits
CHUNK_WIDTH, 100, bits compared per cycle; must divide HV_DIMENSION exactly
NUM_CLASSES, 5, number of prototype slots
LABEL_WIDTH, 3, label width; must satisfy 2^LABEL_WIDTH >= NUM_CLASSES
DISTANCE_WIDTH, 11, distance width; must satisfy 2^DISTANCE_WIDTH > HV_DIMENSION
MODE_WIDTH, 2, mode field width

Ports:
Clk_CI  in  1  clock; all logic on rising edge
Reset_RI  in  1  synchronous, active-high reset
ValidIn_SI  in  1  input transaction valid
ReadyOut_SO  out  1  block can accept an input
ModeIn_SI  in  MODE_WIDTH  00 predict, 01 train, 10 clear-all, 11 reserved
LabelIn_DI  in  LABEL_WIDTH  class slot for train
HypervectorIn_DI  in  [0:HV_DIMENSION-1]  query or prototype
ValidOut_SO  out  1  result valid
ReadyIn_SI  in  1  downstream accepts result
LabelOut_DO  out  LABEL_WIDTH  winning class
DistanceOut_DO  out  DISTANCE_WIDTH  winning Hamming distance
SecondDistanceOut_DO  out  DISTANCE_WIDTH  runner-up distance
NoMatch_SO  out  1  no valid class was stored at predict time

Behaviour:
- Reset: state IDLE; all class valid bits cleared (prototype contents don't-care); ValidOut_SO 0, LabelOut_DO 0, DistanceOut_DO 0, SecondDistanceOut_DO 0, NoMatch_SO 0. ReadyOut_SO is 0 while Reset_RI is high. Reset mid-operation aborts and discards any transaction in flight or pending output.
- States: IDLE, COMPUTE, OUTPUT.
- IDLE: ReadyOut_SO = 1. Accept on rising edge with ValidIn_SI & ReadyOut_SO; inputs are sampled only on that edge.
  - Train: write HypervectorIn_DI to slot LabelIn_DI and set its valid bit; stay IDLE; no result. If LabelIn_DI >= NUM_CLASSES, the write is dropped.
  - Clear-all: clear all valid bits; stay IDLE; no result.
  - Reserved mode: accept and drop.
  - Predict: register the query; reset the class counter c and chunk counter j to 0, accumulator acc to 0, best = second = all-ones, best label 0, found 0; go to COMPUTE.
- COMPUTE: ReadyOut_SO 0. Each cycle, acc += popcount(query[j*CW +: CW] XOR proto[c][j*CW +: CW]).
  - On the last chunk of class c, form d = acc + this chunk's count, then:
    - if valid[c] and d < best: second <= best, best <= d, label <= c, found <= 1;
    - else if valid[c] and d < second: second <= d.
    - Then reset acc and increment c.
  - Invalid classes are still iterated, giving constant latency.
  - Ties: strict compare, so the lowest label wins and an equal distance becomes second.
  - After class NUM_CLASSES-1, chunk last, go to OUTPUT.
- Latency: ValidOut_SO rises exactly NUM_CLASSES*(HV_DIMENSION/CHUNK_WIDTH)+1 rising edges after the accepting edge. Default: 101.
- OUTPUT: ValidOut_SO 1; outputs held stable until ValidOut_SO & ReadyIn_SI on a rising edge, then return to IDLE.
  - ReadyOut_SO is 0 in OUTPUT; no overlap with a new input.
  - If no valid class: LabelOut_DO 0, DistanceOut_DO and SecondDistanceOut_DO all-ones, NoMatch_SO 1.
  - If exactly one valid class: SecondDistanceOut_DO all-ones.
- Outputs retain their last values after the handshake; ValidOut_SO drops to 0.
- Max distance HV_DIMENSION fits DISTANCE_WIDTH without overflow. The all-ones sentinel exceeds any real distance.

Test Plan:
- Reset, then predict with empty memory -> after 101 cycles: ValidOut_SO=1, NoMatch_SO=1, LabelOut_DO=0, DistanceOut_DO=2047, SecondDistanceOut_DO=2047.
- Train class 0 with all-zeros and class 2 with the first 300 bits set; predict the first 100 bits set -> LabelOut_DO=0, DistanceOut_DO=100, SecondDistanceOut_DO=200, NoMatch_SO=0, latency exactly 101.
- Train classes 1 and 3 with an identical vector; predict that vector -> LabelOut_DO=1, DistanceOut_DO=0, SecondDistanceOut_DO=0 (tie goes to the lower label).
- Hold ReadyIn_SI=0 for 20 cycles in OUTPUT -> ValidOut_SO and outputs stable, ReadyOut_SO=0; release -> back to IDLE next cycle, ReadyOut_SO=1.
- Train with LabelIn_DI=6 and clear-all after training class 4 -> next predict reports NoMatch_SO=1; out-of-range write does not corrupt slots 0-4.
- Assert Reset_RI mid-COMPUTE -> next cycle ValidOut_SO=0, ReadyOut_SO=1 after deassert, and all valid bits cleared (next predict gives NoMatch_SO=1).
